// File: rtl/nios_interrupt_nios2_qsys_0_ocimem_ctrl.sv
// nios_interrupt_nios2_qsys_0_ocimem_ctrl
//   Debug RAM controller for the Nios II JTAG debug path. A single-port
//   2**ADDR_W x 32 RAM is shared between JTAG monitor commands (address load,
//   read, read-next, write) and the CPU Avalon-MM debug slave. JTAG requests
//   win arbitration in IDLE; a CPU access always takes two cycles.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   jdo, take_action_ocimem_a/b,     JTAG command word and 1-clk strobes
//   take_no_action_ocimem_a
//   address, chipselect, read, write, byteenable, writedata, debugaccess
//                                    CPU Avalon-MM slave request
//   readdata, waitrequest            CPU Avalon-MM slave response
//   MonDReg, monitor_ready, monitor_error
//                                    JTAG monitor data / status
module nios_interrupt_nios2_qsys_0_ocimem_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] MONDREG_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] J_ACC  = 2'd1;
  localparam logic [1:0] J_DONE = 2'd2;
  localparam logic [1:0] C_ACC  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] mon_areg;
  logic              jtag_pend;
  logic              jtag_wr;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       rd_q;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_we;
  logic              ram_rd;

  logic cpu_req, strobe;
  assign cpu_req = chipselect & (read | write);
  assign strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // jdo bits that carry nothing for this block
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  // Single RAM port mux. The CPU request is issued straight from IDLE so the
  // registered read data is already valid in the C_ACC cycle.
  always_comb begin
    ram_addr  = mon_areg;
    ram_wdata = MonDReg;
    ram_be    = 4'hF;
    ram_we    = 1'b0;
    ram_rd    = 1'b0;
    case (state)
      J_ACC: begin
        ram_we = jtag_wr;
        ram_rd = ~jtag_wr;
      end
      IDLE: if (!jtag_pend && cpu_req) begin
        ram_addr  = address;
        ram_wdata = writedata;
        ram_be    = byteenable;
        ram_rd    = read;
        // read&write is a read; writes without debugaccess are swallowed
        ram_we    = ~read & debugaccess;
      end
      default: ;
    endcase
  end

  // RAM contents are not reset; the write is gated so nothing lands while
  // reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) ram[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rd_q <= '0;
    else if (ram_rd) rd_q <= ram[ram_addr];
  end

  assign readdata    = rd_q;
  assign waitrequest = (state != C_ACC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_areg      <= '0;
      jtag_pend     <= 1'b0;
      jtag_wr       <= 1'b0;
      MonDReg       <= MONDREG_RST;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (jtag_pend) state <= J_ACC;
                 else if (cpu_req) state <= C_ACC;
        J_ACC:   state <= J_DONE;
        J_DONE: begin
          if (!jtag_wr) MonDReg <= rd_q;
          mon_areg      <= mon_areg + ADDR_W'(1);
          jtag_pend     <= 1'b0;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Command decode. While an op is pending every strobe is dropped, so
      // this never races with the J_DONE updates above.
      if (strobe) begin
        if (jtag_pend) begin
          monitor_error <= 1'b1;
        end else if (take_action_ocimem_a) begin
          if (jdo[36]) monitor_error <= 1'b0;
          if (jdo[35]) mon_areg <= jdo[17 +: ADDR_W];
          if (jdo[34]) begin
            jtag_pend     <= 1'b1;
            jtag_wr       <= 1'b0;
            monitor_ready <= 1'b0;
          end
          if (take_action_ocimem_b) monitor_error <= 1'b1;
        end else if (take_action_ocimem_b) begin
          MonDReg       <= jdo[34:3];
          jtag_pend     <= 1'b1;
          jtag_wr       <= 1'b1;
          monitor_ready <= 1'b0;
        end else begin
          jtag_pend     <= 1'b1;
          jtag_wr       <= 1'b0;
          monitor_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_interrupt_nios2_qsys_0_ocimem_ctrl.sv
module tb_nios_interrupt_nios2_qsys_0_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  address;
  logic        chipselect, read, write, debugaccess;
  logic [3:0]  byteenable;
  logic [31:0] writedata, readdata, MonDReg;
  logic        waitrequest, monitor_ready, monitor_error;

  always #5 clk = ~clk;

  nios_interrupt_nios2_qsys_0_ocimem_ctrl #(.ADDR_W(8), .MONDREG_RST(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  int vec = 0;
  int errs = 0;

  // reference model
  logic [31:0] m_ram [256];
  logic [7:0]  m_areg;
  logic [31:0] m_mon;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] mk_a(bit clr, bit ld, bit rd, logic [7:0] ad);
    logic [37:0] j;
    j = '0;
    j[36] = clr; j[35] = ld; j[34] = rd; j[24:17] = ad;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    j[37] = 1'($urandom); j[2:0] = 3'($urandom);
    return j;
  endfunction

  task automatic jtag_cmd(input bit a, input bit b, input bit na, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = a; take_action_ocimem_b = b; take_no_action_ocimem_a = na;
    tick();
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!monitor_ready && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic cpu_access(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be,
                            input bit dbg, input bit rd, input bit wr,
                            output logic [31:0] rdata, output int wcyc, output bit wr_after);
    chipselect = 1; address = a; writedata = wd; byteenable = be;
    debugaccess = dbg; read = rd; write = wr;
    wcyc = 0;
    do begin tick(); wcyc++; end while (waitrequest && wcyc < 30);
    rdata = readdata;
    tick();
    wr_after = waitrequest;
    chipselect = 0; read = 0; write = 0; debugaccess = 0;
  endtask

  function automatic void m_cpu_write(logic [7:0] a, logic [31:0] d, logic [3:0] be, bit dbg);
    if (dbg)
      for (int i = 0; i < 4; i++)
        if (be[i]) m_ram[a][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  task automatic test_reset();
    reset_n = 0;
    jdo = '0; take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    address = '0; chipselect = 0; read = 0; write = 0; byteenable = '0; writedata = '0; debugaccess = 0;
    tick(); tick();
    vec++; if (waitrequest !== 1'b1) begin errs++; $display("FAIL reset_waitreq got=%b exp=1", waitrequest); end
    vec++; if (readdata !== 32'h0) begin errs++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    vec++; if (MonDReg !== 32'h0) begin errs++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
    vec++; if (monitor_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", monitor_ready); end
    vec++; if (monitor_error !== 1'b0) begin errs++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    reset_n = 1;
    m_areg = 0; m_mon = 0;
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] d, rdat; int wc; bit wa;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      cpu_access(8'(i), d, 4'hF, 1, 0, 1, rdat, wc, wa);
      m_ram[i] = d;
      if (wc != 1 || !wa) begin
        vec++; errs++;
        $display("FAIL fill_timing addr=%0d wait_cycles=%0d exp=1 wr_after=%b exp=1", i, wc, wa);
      end
    end
    vec++;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a;
      a = 8'($urandom);
      cpu_access(a, 0, 4'h0, 0, 1, 0, rdat, wc, wa);
      vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL fill_read addr=%h got=%h exp=%h", a, rdat, m_ram[a]); end
    end
  endtask

  task automatic test_jtag_write();
    int cyc; logic [31:0] rdat; int wc; bit wa;
    jtag_cmd(1, 0, 0, mk_a(0, 1, 0, 8'h10));
    m_areg = 8'h10;
    jtag_cmd(0, 1, 0, mk_b(32'hDEADBEEF));   // strobe edge N
    tick(); tick();                           // N+2
    vec++; if (monitor_ready !== 1'b0) begin errs++; $display("FAIL jwr_ready_early got=%b exp=0", monitor_ready); end
    tick();                                   // N+3
    vec++; if (monitor_ready !== 1'b1) begin errs++; $display("FAIL jwr_ready_n3 got=%b exp=1", monitor_ready); end
    m_ram[8'h10] = 32'hDEADBEEF; m_mon = 32'hDEADBEEF; m_areg = 8'h11;
    vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL jwr_mondreg got=%h exp=%h", MonDReg, m_mon); end
    // read-next confirms the address advanced to 0x11
    jtag_cmd(0, 0, 1, '0);
    wait_ready(cyc);
    m_mon = m_ram[m_areg]; m_areg++;
    vec++; if (cyc != 3 || MonDReg !== m_mon) begin errs++; $display("FAIL jwr_readnext cyc=%0d exp=3 got=%h exp=%h", cyc, MonDReg, m_mon); end
    cpu_access(8'h10, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== 32'hDEADBEEF) begin errs++; $display("FAIL cpu_read_10 got=%h exp=deadbeef", rdat); end
    vec++; if (wc != 1 || !wa) begin errs++; $display("FAIL cpu_read_timing wait_cycles=%0d exp=1 wr_after=%b exp=1", wc, wa); end
  endtask

  task automatic test_wrap();
    int cyc;
    jtag_cmd(1, 0, 0, mk_a(0, 1, 1, 8'hFF));
    wait_ready(cyc);
    m_mon = m_ram[8'hFF]; m_areg = 8'h00;
    vec++; if (cyc != 3 || MonDReg !== m_mon) begin errs++; $display("FAIL wrap_rd_ff cyc=%0d got=%h exp=%h", cyc, MonDReg, m_mon); end
    jtag_cmd(0, 0, 1, '0);
    wait_ready(cyc);
    m_mon = m_ram[8'h00]; m_areg = 8'h01;
    vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL wrap_rd_00 got=%h exp=%h", MonDReg, m_mon); end
  endtask

  task automatic test_error();
    int cyc; logic [31:0] rdat; int wc; bit wa; logic [7:0] tgt;
    tgt = m_areg;
    jtag_cmd(0, 0, 1, '0);                     // queued read
    jtag_cmd(0, 1, 0, mk_b(32'h12345678));     // overrun: dropped
    vec++; if (monitor_error !== 1'b1) begin errs++; $display("FAIL err_set got=%b exp=1", monitor_error); end
    wait_ready(cyc);
    m_mon = m_ram[tgt]; m_areg = tgt + 8'd1;
    vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL err_dropped_mondreg got=%h exp=%h", MonDReg, m_mon); end
    vec++; if (monitor_error !== 1'b1) begin errs++; $display("FAIL err_sticky got=%b exp=1", monitor_error); end
    cpu_access(tgt, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== m_ram[tgt]) begin errs++; $display("FAIL err_ram_untouched got=%h exp=%h", rdat, m_ram[tgt]); end
    jtag_cmd(1, 0, 0, mk_a(1, 0, 0, 8'h00));
    vec++; if (monitor_error !== 1'b0) begin errs++; $display("FAIL err_clear got=%b exp=0", monitor_error); end
    // a and b together: a's address load happens, b dropped, error set
    jtag_cmd(1, 1, 0, mk_a(0, 1, 0, 8'h40) | mk_b(32'h0));
    m_areg = 8'h40;
    vec++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin errs++; $display("FAIL err_ab error=%b exp=1 ready=%b exp=1", monitor_error, monitor_ready); end
    jtag_cmd(0, 0, 1, '0);
    wait_ready(cyc);
    m_mon = m_ram[8'h40]; m_areg = 8'h41;
    vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL err_ab_areg got=%h exp=%h", MonDReg, m_mon); end
    jtag_cmd(1, 0, 0, mk_a(1, 0, 0, 8'h00));
    vec++; if (monitor_error !== 1'b0) begin errs++; $display("FAIL err_clear2 got=%b exp=0", monitor_error); end
  endtask

  task automatic test_cpu_be();
    logic [31:0] rdat, d; int wc; bit wa; logic [7:0] a;
    a = 8'h77; d = 32'hA5A5_C3C3;
    cpu_access(a, d, 4'b0011, 0, 0, 1, rdat, wc, wa);
    cpu_access(a, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL be_nodebug got=%h exp=%h", rdat, m_ram[a]); end
    cpu_access(a, d, 4'b0011, 1, 0, 1, rdat, wc, wa);
    m_cpu_write(a, d, 4'b0011, 1);
    cpu_access(a, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL be_low16 got=%h exp=%h", rdat, m_ram[a]); end
    // read and write together act as a read
    cpu_access(a, 32'hFFFF_FFFF, 4'hF, 1, 1, 1, rdat, wc, wa);
    vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL rdwr_as_read got=%h exp=%h", rdat, m_ram[a]); end
    cpu_access(a, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL rdwr_no_write got=%h exp=%h", rdat, m_ram[a]); end
  endtask

  task automatic test_collision();
    logic [31:0] rdat, d; int wc; bit wa;
    d = $urandom;
    jtag_cmd(1, 0, 0, mk_a(0, 1, 0, 8'h22));
    jtag_cmd(0, 1, 0, mk_b(d));
    m_ram[8'h22] = d; m_mon = d; m_areg = 8'h23;
    cpu_access(8'h22, 0, 0, 0, 1, 0, rdat, wc, wa);   // issued while JTAG write pending
    vec++; if (rdat !== d || wc >= 30) begin errs++; $display("FAIL collision got=%h exp=%h wait_cycles=%0d", rdat, d, wc); end
    vec++; if (monitor_ready !== 1'b1) begin errs++; $display("FAIL collision_ready got=%b exp=1", monitor_ready); end
  endtask

  task automatic test_random();
    logic [31:0] rdat, d; int wc, cyc; bit wa; logic [7:0] a; logic [3:0] be; bit dbg, rdb;
    for (int it = 0; it < 60; it++) begin
      d = $urandom; a = 8'($urandom); be = 4'($urandom); dbg = 1'($urandom); rdb = 1'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          cpu_access(a, d, be, dbg, 0, 1, rdat, wc, wa);
          m_cpu_write(a, d, be, dbg);
        end
        1: begin
          cpu_access(a, 0, 0, 0, 1, 0, rdat, wc, wa);
          vec++; if (rdat !== m_ram[a]) begin errs++; $display("FAIL rnd_cpu_read it=%0d addr=%h got=%h exp=%h", it, a, rdat, m_ram[a]); end
        end
        2: begin
          jtag_cmd(1, 0, 0, mk_a(0, 1, rdb, a));
          m_areg = a;
          if (rdb) begin
            wait_ready(cyc);
            m_mon = m_ram[m_areg]; m_areg++;
            vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL rnd_jtag_a it=%0d got=%h exp=%h", it, MonDReg, m_mon); end
          end
        end
        3: begin
          jtag_cmd(0, 1, 0, mk_b(d));
          wait_ready(cyc);
          m_ram[m_areg] = d; m_mon = d; m_areg++;
          vec++; if (MonDReg !== m_mon || cyc != 3) begin errs++; $display("FAIL rnd_jtag_b it=%0d got=%h exp=%h cyc=%0d", it, MonDReg, m_mon, cyc); end
        end
        default: begin
          jtag_cmd(0, 0, 1, '0);
          wait_ready(cyc);
          m_mon = m_ram[m_areg]; m_areg++;
          vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL rnd_jtag_na it=%0d got=%h exp=%h", it, MonDReg, m_mon); end
        end
      endcase
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rdat; int wc, cyc; bit wa; logic [7:0] tgt;
    tgt = m_areg;
    jtag_cmd(0, 1, 0, mk_b(~m_ram[tgt]));   // now in IDLE with write pending
    tick();                                  // J_ACC: write would land at this edge
    reset_n = 0;
    #1;
    vec++; if (waitrequest !== 1'b1 || monitor_ready !== 1'b0 || MonDReg !== 32'h0) begin
      errs++; $display("FAIL midop_reset wr=%b ready=%b mondreg=%h exp 1/0/0", waitrequest, monitor_ready, MonDReg);
    end
    tick();
    reset_n = 1;
    m_areg = 0; m_mon = 0;
    tick(); tick(); tick();
    vec++; if (monitor_ready !== 1'b0) begin errs++; $display("FAIL midop_no_resume got=%b exp=0", monitor_ready); end
    cpu_access(tgt, 0, 0, 0, 1, 0, rdat, wc, wa);
    vec++; if (rdat !== m_ram[tgt]) begin errs++; $display("FAIL midop_no_write got=%h exp=%h", rdat, m_ram[tgt]); end
    jtag_cmd(0, 0, 1, '0);
    wait_ready(cyc);
    m_mon = m_ram[0]; m_areg = 1;
    vec++; if (MonDReg !== m_mon) begin errs++; $display("FAIL midop_areg_reset got=%h exp=%h", MonDReg, m_mon); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_jtag_write();
    test_wrap();
    test_error();
    test_cpu_be();
    test_collision();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
